// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
package sdram_arb_pkg;

    localparam int HADDR_WIDTH_DEF = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic PORT_VIDEO = 1'b0;
    localparam logic PORT_CPU   = 1'b1;

endpackage

// File: rtl/sdram_arb_grant.sv
// Two-input request picker. SDRAM_ARB_RR_EN selects round-robin tie-breaking;
// otherwise port 0 always wins a tie.
module sdram_arb_grant
    import sdram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic valid,
    output logic port,
    output logic next_prio
);

    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            port = prio;
        end else if (req1) begin
            port = PORT_CPU;
        end else begin
            port = PORT_VIDEO;
        end
`ifdef SDRAM_ARB_RR_EN
        next_prio = ~port;
`else
        next_prio = PORT_VIDEO;
`endif
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port (video read / CPU read-write) arbiter in front of an SDRAM controller.
// Tie-break policy is set by SDRAM_ARB_RR_EN inside sdram_arb_grant.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int HADDR_WIDTH = HADDR_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   p0_req,
    input  logic [HADDR_WIDTH-1:0] p0_addr,
    output logic                   p0_ack,
    output logic [15:0]            p0_rdata,
    input  logic                   p1_req,
    input  logic                   p1_we,
    input  logic [HADDR_WIDTH-1:0] p1_addr,
    input  logic [15:0]            p1_wdata,
    output logic                   p1_ack,
    output logic [15:0]            p1_rdata,
    output logic                   sd_rd_enable,
    output logic                   sd_wr_enable,
    output logic [HADDR_WIDTH-1:0] sd_rd_addr,
    output logic [HADDR_WIDTH-1:0] sd_wr_addr,
    output logic [15:0]            sd_wr_data,
    input  logic [15:0]            sd_rd_data,
    input  logic                   sd_rd_ready,
    input  logic                   sd_busy
);

    state_t                 state, state_next;
    logic                   start;
    logic                   lat_port, lat_we;
    logic [HADDR_WIDTH-1:0] lat_addr;
    logic [15:0]            lat_wdata;
    logic                   prio;
    logic                   gnt_valid, gnt_port, gnt_next_prio;

    sdram_arb_grant u_grant (
        .req0      (p0_req),
        .req1      (p1_req),
        .prio      (prio),
        .valid     (gnt_valid),
        .port      (gnt_port),
        .next_prio (gnt_next_prio)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (!sd_busy && gnt_valid) begin
                    start      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: if (sd_busy) state_next = WAIT;
            WAIT:  if (lat_we ? !sd_busy : sd_rd_ready) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // The latched request is the only source of controller address/data, so they
    // cannot move while a transaction is in flight even if the host changes inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_port  <= PORT_VIDEO;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            prio      <= PORT_VIDEO;
        end else if (start) begin
            lat_port  <= gnt_port;
            lat_we    <= (gnt_port == PORT_CPU) && p1_we;
            lat_addr  <= (gnt_port == PORT_CPU) ? p1_addr : p0_addr;
            lat_wdata <= (gnt_port == PORT_CPU) ? p1_wdata : '0;
            prio      <= gnt_next_prio;
        end
    end

    // Read data lands directly in the owning port's register so it is valid with ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else if (state == WAIT && !lat_we && sd_rd_ready) begin
            if (lat_port == PORT_CPU) p1_rdata <= sd_rd_data;
            else                      p0_rdata <= sd_rd_data;
        end
    end

    assign sd_rd_enable = (state == ISSUE) && !lat_we;
    assign sd_wr_enable = (state == ISSUE) &&  lat_we;
    assign sd_rd_addr   = lat_addr;
    assign sd_wr_addr   = lat_addr;
    assign sd_wr_data   = lat_wdata;
    assign p0_ack       = (state == DONE) && (lat_port == PORT_VIDEO);
    assign p1_ack       = (state == DONE) && (lat_port == PORT_CPU);

endmodule
